// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default geometry and FSM state encodings.
package program_loader_pkg;

   localparam int PL_ADDR_W = 4;
   localparam int PL_DATA_W = 4;
   localparam int PL_DEPTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/program_loader_edge_detect_rise.sv
// Registers a level input once and reports a one-cycle pulse on its rising edge.
module edge_detect_rise (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic pulse
);

   logic cur_q, cur_d;
   logic prev_q, prev_d;

   always_comb begin
      cur_d  = sig_in;
      prev_d = cur_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         cur_q  <= cur_d;
         prev_q <= prev_d;
      end
   end

   assign pulse = cur_q & ~prev_q;

endmodule

// File: rtl/program_loader.sv
// Program memory writer: clears the RAM, accepts keyed-in words, then releases the CPU.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = PL_ADDR_W,
   parameter int DATA_W = PL_DATA_W,
   parameter int DEPTH  = PL_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              wr_btn,
   input  logic              finish,
   input  logic [DATA_W-1:0] data_in,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   word_count,
   output logic              full
);

   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic start_p, wr_p, fin_p;

   edge_detect_rise u_start_edge  (.clk(clk), .reset(reset), .sig_in(start),  .pulse(start_p));
   edge_detect_rise u_wr_edge     (.clk(clk), .reset(reset), .sig_in(wr_btn), .pulse(wr_p));
   edge_detect_rise u_finish_edge (.clk(clk), .reset(reset), .sig_in(finish), .pulse(fin_p));

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                full_q, full_d;

   // Next-state, counter and write-port logic; all outputs are registered from here.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            cpu_hold_d = 1'b0;
            if (start_p) begin
               state_d    = ST_CLEAR;
               addr_d     = {ADDR_W{1'b0}};
               count_d    = {(ADDR_W+1){1'b0}};
               cpu_hold_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_CLEAR: begin
            cpu_hold_d  = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {DATA_W{1'b0}};
            if (addr_q == LAST_ADDR) begin
               state_d = ST_LOAD;
               addr_d  = {ADDR_W{1'b0}};
            end else begin
               addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         ST_LOAD: begin
            cpu_hold_d = 1'b1;
            if (wr_p && (count_q < DEPTH_C)) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = data_in;
               count_d     = count_q + {{ADDR_W{1'b0}}, 1'b1};
               if (addr_q != LAST_ADDR) begin
                  addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end else begin
                  addr_d = addr_q;
               end
            end else begin
               mem_we_d = 1'b0;
            end
            // A same-cycle finish still lets the pending word land before leaving.
            if ((count_d == DEPTH_C) || fin_p) begin
               state_d    = ST_DONE;
               cpu_hold_d = 1'b0;
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            cpu_hold_d = 1'b0;
         end
      endcase
      full_d = (count_d == DEPTH_C);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         count_q     <= {(ADDR_W+1){1'b0}};
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         cpu_hold_q  <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         full_q      <= full_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign word_count = count_q;
   assign full       = full_q;

endmodule
